bp_sacc_lce_req_wh_tx: RTL and testbench



---
 rtl/bp_sacc_pkg.sv | 32 +++
 rtl/bp_sacc_wh_flit_mux.sv | 26 ++
 rtl/bp_sacc_lce_req_wh_tx.sv | 143 ++++++++++++++
 tb/tb_bp_sacc_lce_req_wh_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_sacc_pkg.sv
// Shared definitions for the streaming-accelerator LCE request wormhole path.
//   bp_sacc_wh_hdr_s    : wormhole routing header {cid, len, cord}, cord in the LSBs
//   bp_sacc_wh_state_e  : packetizer FSM states
//   bp_sacc_hdr_flits() : number of flits occupied by the routing + LCE header
package bp_sacc_pkg;

    localparam int unsigned wh_cord_width_gp = 7;
    localparam int unsigned wh_len_width_gp  = 4;
    localparam int unsigned wh_cid_width_gp  = 2;

    typedef struct packed {
        logic [wh_cid_width_gp-1:0]  cid;
        logic [wh_len_width_gp-1:0]  len;
        logic [wh_cord_width_gp-1:0] cord;
    } bp_sacc_wh_hdr_s;

    typedef enum logic {
        e_ready,
        e_send
    } bp_sacc_wh_state_e;

    function automatic int unsigned bp_sacc_hdr_flits(
        input int unsigned cord_w,
        input int unsigned len_w,
        input int unsigned cid_w,
        input int unsigned hdr_w,
        input int unsigned flit_w
    );
        return (cord_w + len_w + cid_w + hdr_w + flit_w - 1) / flit_w;
    endfunction

endpackage

// File: rtl/bp_sacc_wh_flit_mux.sv
// Combinational flit selector: returns flit cnt_i of a registered packet image.
//   image_i : packet image, flit k at [k*flit_width_p +: flit_width_p]
//   cnt_i   : flit index (counter lives in the parent)
//   flit_o  : selected flit, zero when cnt_i is beyond the image
module bp_sacc_wh_flit_mux
    import bp_sacc_pkg::*;
#(
    parameter int unsigned flit_width_p = 64,
    parameter int unsigned num_flits_p  = 10,
    parameter int unsigned cnt_width_p  = 4
) (
    input  logic [num_flits_p*flit_width_p-1:0] image_i,
    input  logic [cnt_width_p-1:0]              cnt_i,
    output logic [flit_width_p-1:0]             flit_o
);

    always_comb begin
        flit_o = '0;
        for (int unsigned i = 0; i < num_flits_p; i++) begin
            if (cnt_i == cnt_width_p'(i)) begin
                flit_o = image_i[i*flit_width_p +: flit_width_p];
            end
        end
    end

endmodule

// File: rtl/bp_sacc_lce_req_wh_tx.sv
// Tile-side LCE request packetizer: accepts one request (cord, cid, header,
// variable-length payload), registers it, and serializes it into wormhole
// flits on a ready/valid link. Header region {hdr, cid, len, cord} is
// zero-padded to whole flits, followed by the payload flits.
//   clk_i / reset_i (async, active low)
//   dst_cord_i, dst_cid_i, hdr_i, data_i, data_flits_i, v_i -> request in
//   ready_and_o                                            -> request accept
//   link_data_o, link_v_o / link_ready_and_i               -> flit link
// Optional: define BP_SACC_WH_TX_BACK2BACK_EN to accept the next request on
// the last flit handshake so packets stream without an idle cycle.
module bp_sacc_lce_req_wh_tx
    import bp_sacc_pkg::*;
#(
    parameter int unsigned flit_width_p     = 64,
    parameter int unsigned cord_width_p     = 7,
    parameter int unsigned len_width_p      = 4,
    parameter int unsigned cid_width_p      = 2,
    parameter int unsigned hdr_width_p      = 80,
    parameter int unsigned max_data_flits_p = 8,
    localparam int unsigned data_flits_width_lp = $clog2(max_data_flits_p + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [cord_width_p-1:0]                dst_cord_i,
    input  logic [cid_width_p-1:0]                 dst_cid_i,
    input  logic [hdr_width_p-1:0]                 hdr_i,
    input  logic [max_data_flits_p*flit_width_p-1:0] data_i,
    input  logic [data_flits_width_lp-1:0]         data_flits_i,
    input  logic                                   v_i,
    output logic                                   ready_and_o,
    output logic [flit_width_p-1:0]                link_data_o,
    output logic                                   link_v_o,
    input  logic                                   link_ready_and_i
);

    localparam int unsigned hdr_flits_lp =
        bp_sacc_hdr_flits(cord_width_p, len_width_p, cid_width_p, hdr_width_p, flit_width_p);
    localparam int unsigned num_flits_lp    = hdr_flits_lp + max_data_flits_p;
    localparam int unsigned hdr_region_w_lp = hdr_flits_lp * flit_width_p;
    localparam int unsigned image_w_lp      = num_flits_lp * flit_width_p;

    if (hdr_flits_lp + max_data_flits_p - 1 >= (1 << len_width_p)) begin : g_len_width_chk
        $error("len_width_p too narrow for the longest packet");
    end

    bp_sacc_wh_state_e         state_r;
    logic [len_width_p-1:0]    cnt_r;
    logic [len_width_p-1:0]    total_len_r;
    logic [image_w_lp-1:0]     image_r;

    logic [len_width_p-1:0]    len_field;
    logic [hdr_region_w_lp-1:0] hdr_region;
    logic [image_w_lp-1:0]     image_next;
    logic                      accept;
    logic                      last_flit;

    // Flits after the first; truncation to the field width is intentional.
    assign len_field = len_width_p'(hdr_flits_lp - 1) + len_width_p'(data_flits_i);

    always_comb begin
        hdr_region = '0;
        hdr_region[0 +: cord_width_p]                                    = dst_cord_i;
        hdr_region[cord_width_p +: len_width_p]                          = len_field;
        hdr_region[cord_width_p+len_width_p +: cid_width_p]              = dst_cid_i;
        hdr_region[cord_width_p+len_width_p+cid_width_p +: hdr_width_p]  = hdr_i;
    end

    assign image_next = {data_i, hdr_region};
    assign last_flit  = (cnt_r == total_len_r);

    always_comb begin
        ready_and_o = 1'b0;
        case (state_r)
            e_ready: ready_and_o = 1'b1;
            e_send: begin
`ifdef BP_SACC_WH_TX_BACK2BACK_EN
                ready_and_o = link_ready_and_i & last_flit;
`else
                ready_and_o = 1'b0;
`endif
            end
        endcase
    end

    assign accept   = v_i & ready_and_o;
    assign link_v_o = (state_r == e_send);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r     <= e_ready;
            cnt_r       <= '0;
            total_len_r <= '0;
            image_r     <= '0;
        end else begin
            case (state_r)
                e_ready: begin
                    if (accept) begin
                        image_r     <= image_next;
                        total_len_r <= len_field;
                        cnt_r       <= '0;
                        state_r     <= e_send;
                    end
                end
                e_send: begin
                    if (link_ready_and_i) begin
                        if (last_flit) begin
                            cnt_r <= '0;
`ifdef BP_SACC_WH_TX_BACK2BACK_EN
                            // Accept on the closing handshake reloads in place.
                            if (accept) begin
                                image_r     <= image_next;
                                total_len_r <= len_field;
                            end else begin
                                state_r <= e_ready;
                            end
`else
                            state_r <= e_ready;
`endif
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    bp_sacc_wh_flit_mux #(
        .flit_width_p (flit_width_p),
        .num_flits_p  (num_flits_lp),
        .cnt_width_p  (len_width_p)
    ) u_flit_mux (
        .image_i (image_r),
        .cnt_i   (cnt_r),
        .flit_o  (link_data_o)
    );

    a_data_flits_range: assert property (
        @(posedge clk_i) disable iff (!reset_i)
        accept |-> (32'(data_flits_i) <= max_data_flits_p)
    );

endmodule

// File: tb/tb_bp_sacc_lce_req_wh_tx.sv
module tb_bp_sacc_lce_req_wh_tx;
    import bp_sacc_pkg::*;

    localparam int FW = 64;
    localparam int ND = 8;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b0;
    logic [6:0]        dst_cord_i = '0;
    logic [1:0]        dst_cid_i = '0;
    logic [79:0]       hdr_i = '0;
    logic [ND*FW-1:0]  data_i = '0;
    logic [3:0]        data_flits_i = '0;
    logic              v_i = 1'b0;
    logic              ready_and_o;
    logic [FW-1:0]     link_data_o;
    logic              link_v_o;
    logic              link_ready_and_i = 1'b0;

    always #5 clk_i = ~clk_i;

    bp_sacc_lce_req_wh_tx #(
        .flit_width_p     (64),
        .cord_width_p     (7),
        .len_width_p      (4),
        .cid_width_p      (2),
        .hdr_width_p      (80),
        .max_data_flits_p (8)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .dst_cord_i       (dst_cord_i),
        .dst_cid_i        (dst_cid_i),
        .hdr_i            (hdr_i),
        .data_i           (data_i),
        .data_flits_i     (data_flits_i),
        .v_i              (v_i),
        .ready_and_o      (ready_and_o),
        .link_data_o      (link_data_o),
        .link_v_o         (link_v_o),
        .link_ready_and_i (link_ready_and_i)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [6:0]  cord;
        logic [1:0]  cid;
        logic [79:0] hdr;
        logic [3:0]  nd;
        logic [63:0] seed;
        logic [3:0]  exp_len;
        int          exp_total;
        bit          stall;
        bit          scramble;
    } pkt_t;

    pkt_t tbl[4];

    // Reference image: 2 header flits (13-bit routing header + 80-bit LCE header), then payload.
    function automatic logic [63:0] exp_flit(input pkt_t p, input int k);
        logic [639:0]    img;
        bp_sacc_wh_hdr_s h;
        img    = '0;
        h.cord = p.cord;
        h.cid  = p.cid;
        h.len  = p.exp_len;
        img[12:0]  = h;
        img[92:13] = p.hdr;
        for (int i = 0; i < ND; i++)
            if (i < int'(p.nd)) img[128 + 64*i +: 64] = p.seed + 64'(i);
        return img[64*k +: 64];
    endfunction

    task automatic drive_fields(input pkt_t p);
        dst_cord_i   = p.cord;
        dst_cid_i    = p.cid;
        hdr_i        = p.hdr;
        data_flits_i = p.nd;
        for (int i = 0; i < ND; i++)
            data_i[64*i +: 64] = (i < int'(p.nd)) ? p.seed + 64'(i) : '1;
    endtask

    task automatic scramble_inputs();
        dst_cord_i   = 7'($urandom);
        dst_cid_i    = 2'($urandom);
        hdr_i        = {16'($urandom), $urandom, $urandom};
        data_flits_i = 4'($urandom_range(0, ND));
        for (int i = 0; i < ND; i++) data_i[64*i +: 64] = {$urandom, $urandom};
    endtask

    task automatic send_and_check(input pkt_t p, input string tag);
        int k, cyc;
        bit lr, prev_stall;
        logic [63:0] prev_data;
        @(negedge clk_i);
        drive_fields(p);
        v_i = 1'b1;
        link_ready_and_i = 1'b0;
        chk({tag, "_accept_rdy"}, 64'(ready_and_o), 64'd1);
        @(negedge clk_i);
        v_i = 1'b0;
        if (p.scramble) scramble_inputs();
        k = 0; cyc = 0; prev_stall = 0; prev_data = '0;
        while (k < p.exp_total && cyc < 200) begin
            lr = p.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            link_ready_and_i = lr;
            chk({tag, "_valid"}, 64'(link_v_o), 64'd1);
            chk({tag, "_flit"}, link_data_o, exp_flit(p, k));
            if (prev_stall) chk({tag, "_stall_hold"}, link_data_o, prev_data);
            if (k == 0) chk({tag, "_len_field"}, 64'(link_data_o[10:7]), 64'(p.exp_len));
            prev_stall = !lr;
            prev_data  = link_data_o;
            @(negedge clk_i);
            if (p.scramble) scramble_inputs();
            if (lr) k++;
            cyc++;
        end
        chk({tag, "_flit_count"}, 64'(k), 64'(p.exp_total));
        link_ready_and_i = 1'b0;
        chk({tag, "_idle_v"}, 64'(link_v_o), 64'd0);
        chk({tag, "_idle_rdy"}, 64'(ready_and_o), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pkt_t pa, pb, pm;
        logic [63:0] expq[$];
        int seen, bubbles, cyc, which;
        bit started, acc;

        tbl[0] = '{cord: 7'd5,    cid: 2'd1, hdr: 80'hA5A5_A5A5_A5A5_A5A5_A5A5, nd: 4'd0,
                   seed: 64'h0,   exp_len: 4'd1, exp_total: 2,  stall: 0, scramble: 0};
        tbl[1] = '{cord: 7'h7F,   cid: 2'd3, hdr: 80'h1234_5678_9ABC_DEF0_1122, nd: 4'd8,
                   seed: 64'h0,   exp_len: 4'd9, exp_total: 10, stall: 1, scramble: 0};
        tbl[2] = '{cord: 7'd0,    cid: 2'd2, hdr: 80'hFFFF_0000_FFFF_0000_FFFF, nd: 4'd1,
                   seed: 64'hDEAD_BEEF_0000_0000, exp_len: 4'd2, exp_total: 3, stall: 0, scramble: 0};
        tbl[3] = '{cord: 7'h2A,   cid: 2'd0, hdr: 80'hC0DE_CAFE_F00D_1357_2468, nd: 4'd3,
                   seed: 64'h5555_0000_AAAA_0000, exp_len: 4'd4, exp_total: 5, stall: 1, scramble: 1};

        // Reset held with a pending request: nothing may be emitted.
        drive_fields(tbl[0]);
        v_i = 1'b1;
        link_ready_and_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("rst_link_v", 64'(link_v_o), 64'd0);
        end
        v_i = 1'b0;
        link_ready_and_i = 1'b0;
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", 64'(ready_and_o), 64'd1);
        chk("rst_link_v_after", 64'(link_v_o), 64'd0);

        for (int i = 0; i < 4; i++) send_and_check(tbl[i], $sformatf("vec%0d", i));

        // Mid-packet reset after flit 3 of a 10-flit packet.
        pm = tbl[1];
        pm.stall = 0;
        @(negedge clk_i);
        drive_fields(pm);
        v_i = 1'b1;
        @(negedge clk_i);
        v_i = 1'b0;
        link_ready_and_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("midrst_flit3", link_data_o, exp_flit(pm, 3));
        #2 reset_i = 1'b0;
        #1 chk("midrst_link_v", 64'(link_v_o), 64'd0);
        @(negedge clk_i);
        chk("midrst_link_v_held", 64'(link_v_o), 64'd0);
        reset_i = 1'b1;
        link_ready_and_i = 1'b0;
        pm = tbl[0];
        pm.cord = 7'd9;
        pm.hdr  = 80'h0F0F_0F0F_0F0F_0F0F_0F0F;
        send_and_check(pm, "postrst");

        // Two 3-flit packets offered back to back with the link always ready.
        pa = '{cord: 7'd3, cid: 2'd1, hdr: 80'hAAAA_1111_2222_3333_4444, nd: 4'd1,
               seed: 64'h100, exp_len: 4'd2, exp_total: 3, stall: 0, scramble: 0};
        pb = '{cord: 7'd9, cid: 2'd2, hdr: 80'hBBBB_5555_6666_7777_8888, nd: 4'd1,
               seed: 64'h200, exp_len: 4'd2, exp_total: 3, stall: 0, scramble: 0};
        for (int k = 0; k < 3; k++) expq.push_back(exp_flit(pa, k));
        for (int k = 0; k < 3; k++) expq.push_back(exp_flit(pb, k));
        @(negedge clk_i);
        drive_fields(pa);
        v_i = 1'b1;
        link_ready_and_i = 1'b1;
        seen = 0; bubbles = 0; started = 0; which = 0; cyc = 0;
        while (seen < 6 && cyc < 40) begin
            if (link_v_o) begin
                chk("b2b_flit", link_data_o, expq.pop_front());
                seen++;
                started = 1;
            end else if (started) begin
                bubbles++;
            end
            acc = v_i && ready_and_o;
            @(negedge clk_i);
            if (acc) begin
                if (which == 0) begin
                    drive_fields(pb);
                    which = 1;
                end else begin
                    v_i = 1'b0;
                end
            end
            cyc++;
        end
        chk("b2b_flit_count", 64'(seen), 64'd6);
`ifdef BP_SACC_WH_TX_BACK2BACK_EN
        chk("b2b_bubbles", 64'(bubbles), 64'd0);
`else
        chk("b2b_bubbles", 64'(bubbles), 64'd1);
`endif
        v_i = 1'b0;
        link_ready_and_i = 1'b0;
        chk("b2b_idle_v", 64'(link_v_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
